// File: rtl/muldiv_if.sv
// muldiv_if: issue and writeback bundle between the LEGv8 control path and muldiv_unit
interface muldiv_if #(
  parameter int WIDTH = 64,
  parameter int REG_AW = 5
);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [REG_AW-1:0] dest_reg;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic [REG_AW-1:0] result_reg;
  logic result_write;
  modport master(
    output start, op, op_a, op_b, dest_reg,
    input busy, done, result, result_reg, result_write
  );
  modport slave(
    input start, op, op_a, op_b, dest_reg,
    output busy, done, result, result_reg, result_write
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency radix-2 MUL/UMULH/UDIV/SDIV execute unit for the LEGv8 datapath
module muldiv_unit #(
  parameter int WIDTH = 64,
  parameter int REG_AW = 5,
  parameter int ZERO_REG = 31
) (
  input logic clk,
  input logic rst_n,
  muldiv_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
  localparam int CW = $clog2(WIDTH + 1);
  logic [1:0] state;
  logic [1:0] op;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [REG_AW-1:0] result_reg;
  logic neg;
  logic take;
  logic ge;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH-1:0] diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  // A new op may be accepted from IDLE or from DONE, giving a WIDTH+3 issue interval
  assign take = bus.start && (state == IDLE || state == DONE);
  // Shift-add: acc = {partial product, remaining multiplier bits}
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
  assign mul_next = {sum, acc[WIDTH-1:1]};
  // Restoring divide: acc = {remainder, dividend bits shifting into quotient}
  assign rem = acc[2*WIDTH-1:WIDTH-1];
  assign ge = rem >= {1'b0, b};
  assign diff = rem[WIDTH-1:0] - b;
  assign div_next = {ge ? diff : rem[WIDTH-1:0], acc[WIDTH-2:0], ge};
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.result = result;
  assign bus.result_reg = result_reg;
  assign bus.result_write = bus.done && result_reg != REG_AW'(ZERO_REG);
  // Control FSM and datapath; the first RUN cycle (cnt==WIDTH) takes SDIV magnitudes, then WIDTH radix-2 steps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      cnt <= '0;
      acc <= '0;
      b <= '0;
      neg <= 1'b0;
      result <= '0;
      result_reg <= '0;
    end else if (take) begin
      state <= RUN;
      op <= bus.op;
      cnt <= CW'(WIDTH);
      acc <= {{WIDTH{1'b0}}, bus.op_a};
      b <= bus.op_b;
      neg <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
      result_reg <= bus.dest_reg;
    end else if (state == DONE) begin
      state <= IDLE;
    end else if (state == FIX) begin
      state <= DONE;
      result <= !op[1] ? (op[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0]) :
                b == '0 ? '0 :
                op[0] && neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else if (state == RUN) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) state <= FIX;
      if (cnt == CW'(WIDTH)) begin
        if (op == 2'd3) begin
          acc[WIDTH-1:0] <= acc[WIDTH-1] ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          b <= b[WIDTH-1] ? -b : b;
        end
      end else begin
        acc <= op[1] ? div_next : mul_next;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  typedef struct {
    logic [1:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0] d;
    longint e;
  } txn_t;
  logic clk = 0;
  logic rst_n = 1;
  longint cyc = 0;
  int pass_n = 0;
  int total_n = 0;
  bit was_done = 0;
  txn_t exp_q[$];
  txn_t t;
  muldiv_if #(.WIDTH(64), .REG_AW(5)) bus();
  muldiv_unit #(.WIDTH(64), .REG_AW(5), .ZERO_REG(31)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Reference: plain arithmetic on the ARMv8 rules
  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    p = {64'd0, a} * {64'd0, b};
    sa = a;
    sb = b;
    if (op == 2'd0) return p[63:0];
    if (op == 2'd1) return p[127:64];
    if (b == 64'd0) return 64'd0;
    if (op == 2'd2) return a / b;
    if (a == MIN && b == 64'hFFFF_FFFF_FFFF_FFFF) return MIN;
    q = sa / sb;
    return q;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask
  // Compare process: every result pulse against the model, plus Busy/ResultWrite framing
  always @(negedge clk) if (rst_n) begin
    if (was_done) begin
      check("busy_after_done", bus.busy, 64'(exp_q.size() > 0 && exp_q[0].e == cyc));
      was_done = 0;
    end
    if (bus.done) begin
      if (exp_q.size() == 0) check("spurious_done", 1, 0);
      else begin
        t = exp_q.pop_front();
        check("result", bus.result, model(t.op, t.a, t.b));
        check("result_reg", 64'(bus.result_reg), 64'(t.d));
        check("result_write", 64'(bus.result_write), 64'(t.d != 5'd31));
        check("latency", 64'(cyc - t.e), 64'd66);
        check("busy_in_done", 64'(bus.busy), 1);
        was_done = 1;
      end
    end else check("write_without_done", 64'(bus.result_write), 0);
  end
  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
    int n = 0;
    while (bus.busy && !bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("issue_timeout", 0, 1);
    bus.start = 1;
    bus.op = op;
    bus.op_a = a;
    bus.op_b = b;
    bus.dest_reg = d;
    exp_q.push_back('{op, a, b, d, cyc + 1});
    @(negedge clk);
    bus.start = 0;
    bus.op = 2'($urandom);
    bus.op_a = {$urandom, $urandom};
    bus.op_b = {$urandom, $urandom};
    bus.dest_reg = 5'($urandom);
    check("busy_on_issue", 64'(bus.busy), 1);
  endtask
  task automatic wait_done(output logic [63:0] r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 200);
    if (!bus.done) check("done_timeout", 0, 1);
    r = bus.result;
  endtask
  initial begin
    logic [63:0] r;
    logic [63:0] a;
    logic [63:0] b;
    int nd;
    int n;
    bus.start = 0;
    bus.op = 0;
    bus.op_a = 0;
    bus.op_b = 0;
    bus.dest_reg = 0;
    #1 rst_n = 0;
    #11;
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_result", bus.result, 0);
    check("rst_result_reg", 64'(bus.result_reg), 0);
    check("rst_result_write", 64'(bus.result_write), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    issue(2'd0, 64'h0000_0001_0000_0003, 64'd5, 5'd9);
    wait_done(r);
    check("mul_lit", r, 64'h0000_0005_0000_000F);
    check("mul_lit_reg", 64'(bus.result_reg), 64'd9);
    check("mul_lit_write", 64'(bus.result_write), 1);
    repeat (3) @(negedge clk);
    issue(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4);
    wait_done(r);
    check("umulh_lit", r, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5);
    wait_done(r);
    check("mul_ones_lit", r, 64'd1);
    issue(2'd3, -64'd7, 64'd2, 5'd6);
    wait_done(r);
    check("sdiv_lit", r, 64'hFFFF_FFFF_FFFF_FFFD);
    repeat (2) @(negedge clk);
    issue(2'd2, 64'd100, 64'd7, 5'd3);
    repeat (9) @(negedge clk);
    bus.start = 1;
    bus.op = 2'd0;
    bus.op_a = 64'd3;
    bus.op_b = 64'd3;
    bus.dest_reg = 5'd1;
    @(negedge clk);
    bus.start = 0;
    wait_done(r);
    check("udiv_lit_ignored_start", r, 64'd14);
    check("udiv_lit_reg", 64'(bus.result_reg), 64'd3);
    repeat (4) @(negedge clk);
    issue(2'd2, 64'd12345, 64'd0, 5'd7);
    wait_done(r);
    check("udiv_zero_lit", r, 64'd0);
    issue(2'd3, MIN, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
    wait_done(r);
    check("sdiv_ovf_lit", r, MIN);
    issue(2'd0, 64'd3, 64'd4, 5'd31);
    wait_done(r);
    check("xzr_lit", r, 64'd12);
    check("xzr_done", 64'(bus.done), 1);
    check("xzr_write", 64'(bus.result_write), 0);
    repeat (5) @(negedge clk);
    check("result_hold", bus.result, 64'd12);
    issue(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd2);
    repeat (29) @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_busy", 64'(bus.busy), 0);
    check("abort_done", 64'(bus.done), 0);
    check("abort_result", bus.result, 0);
    check("abort_result_reg", 64'(bus.result_reg), 0);
    check("abort_result_write", 64'(bus.result_write), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    nd = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("no_done_after_abort", 64'(nd), 0);
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: begin a = MIN; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        2: b = 64'($urandom_range(1, 1000));
        3: b = {32'd0, $urandom};
        default: ;
      endcase
      issue(2'($urandom), a, b, 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
